iir_filter_mc: RTL

Multi-channel, time-multiplexed direct-form-I IIR filter with runtime-loadable coefficients and one shared multiply-accumulate unit. It is the parametrised successor of the fixed third-order 50 Hz filter. Order, word widths and channel count are generics, input and output are signed, and each channel keeps its own history. It sits between the sample sources, such as the theremin oscillator front-end, and the downstream audio/pitch path.

---
 rtl/iir_pkg.sv | 34 +++
 rtl/iir_mac.sv | 45 ++++
 rtl/iir_filter_mc.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// Shared types and helpers for the multi-channel time-multiplexed IIR filter.
package iir_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC_A = 3'd1,
        MAC_B = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } iir_state_t;

    localparam int SAT_W = 128;

    function automatic int q_bits(input int int_b, input int frac_b);
        return int_b + frac_b + 1;
    endfunction

    // Clamp a wide signed value into the signed range of an n-bit word.
    function automatic logic signed [SAT_W-1:0] sat_q(input logic signed [SAT_W-1:0] v,
                                                      input int n);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (128'sd1 <<< (n - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (n - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared multiply-accumulate: registered signed product feeding an accumulator
// that adds the previous cycle's product when enabled.
module iir_mac
    import iir_pkg::*;
#(
    parameter int Q_BITS = 32,
    parameter int ACC_W  = 67
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr_i,
    input  logic                     acc_en_i,
    input  logic signed [Q_BITS-1:0] opa_i,
    input  logic signed [Q_BITS-1:0] opb_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*Q_BITS-1:0] prod_d, prod_q;
    logic signed [ACC_W-1:0]    acc_d, acc_q;

    always_comb begin
        prod_d = (2*Q_BITS)'(opa_i) * (2*Q_BITS)'(opb_i);
        acc_d  = acc_q;
        if (clr_i) begin
            acc_d = {ACC_W{1'b0}};
        end else if (acc_en_i) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end else begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prod_q <= {(2*Q_BITS){1'b0}};
            acc_q  <= {ACC_W{1'b0}};
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/iir_filter_mc.sv
// Multi-channel direct-form-I IIR filter sharing one MAC across channels and taps.
// Define IIR_SAT_EN to clamp y to [-1, 1) instead of two's-complement wrapping.
module iir_filter_mc
    import iir_pkg::*;
#(
    parameter int  IO_B   = 16,
    parameter int  INT_B  = 7,
    parameter int  FRAC_B = 24,
    parameter int  NA     = 2,
    parameter int  NB     = 3,
    parameter int  NCH    = 2,
    localparam int Q_BITS = q_bits(INT_B, FRAC_B),
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW     = (NA + NB > 1) ? $clog2(NA + NB) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [IO_B-1:0]   in_data,
    input  logic [CH_W-1:0]          in_ch,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [Q_BITS-1:0] coef_wdata,
    input  logic                     hist_clr,
    output logic signed [IO_B-1:0]   out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid
);

    localparam int ACC_W = 2 * Q_BITS + $clog2(NA + NB);
    localparam int NMAX  = (NA > NB) ? NA : NB;
    localparam int CNT_W = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int XSH   = FRAC_B - IO_B + 1;

    iir_state_t               state_d, state_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;
    logic [CH_W-1:0]          ch_d, ch_q;
    logic signed [Q_BITS-1:0] x_hist_d [NCH][NB];
    logic signed [Q_BITS-1:0] x_hist_q [NCH][NB];
    logic signed [Q_BITS-1:0] y_hist_d [NCH][NA];
    logic signed [Q_BITS-1:0] y_hist_q [NCH][NA];
    logic signed [Q_BITS-1:0] coef_d [NA+NB];
    logic signed [Q_BITS-1:0] coef_q [NA+NB];
    logic signed [IO_B-1:0]   res_d, res_q;
    logic [CH_W-1:0]          res_ch_d, res_ch_q;
    logic                     res_vld_d, res_vld_q;
    logic signed [IO_B-1:0]   out_data_d, out_data_q;
    logic [CH_W-1:0]          out_ch_d, out_ch_q;
    logic                     out_valid_d, out_valid_q;

    logic                     idle_s, accept_s, acc_en_s;
    logic signed [Q_BITS-1:0] x_in_s, opa_s, opb_s, y_s;
    logic signed [ACC_W-1:0]  acc_s;

    assign idle_s   = (state_q == IDLE);
    assign in_ready = idle_s && !coef_we && !hist_clr;
    assign accept_s = in_ready && in_valid;
    assign x_in_s   = Q_BITS'(in_data) <<< XSH;
    // The product register delays each tap by one cycle, so accumulation
    // starts on the second MAC_A cycle and ends in FLUSH.
    assign acc_en_s = ((state_q == MAC_A) && (cnt_q != CNT_W'(0))) ||
                      (state_q == MAC_B) || (state_q == FLUSH);

`ifdef IIR_SAT_EN
    logic signed [SAT_W-1:0] sat_w_s;
    assign sat_w_s = sat_q(SAT_W'(acc_s >>> FRAC_B), FRAC_B + 1);
    assign y_s     = Q_BITS'(sat_w_s);
`else
    assign y_s = Q_BITS'(acc_s >>> FRAC_B);
`endif

    iir_mac #(
        .Q_BITS (Q_BITS),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (accept_s),
        .acc_en_i (acc_en_s),
        .opa_i    (opa_s),
        .opb_i    (opb_s),
        .acc_o    (acc_s)
    );

    always_comb begin
        opa_s = {Q_BITS{1'b0}};
        opb_s = {Q_BITS{1'b0}};
        case (state_q)
            MAC_A: begin
                for (int k = 0; k < NA; k++) begin
                    opa_s = (cnt_q == CNT_W'(k)) ? coef_q[k] : opa_s;
                    for (int c = 0; c < NCH; c++) begin
                        opb_s = ((cnt_q == CNT_W'(k)) && (ch_q == CH_W'(c))) ?
                                y_hist_q[c][k] : opb_s;
                    end
                end
            end
            MAC_B: begin
                for (int k = 0; k < NB; k++) begin
                    opa_s = (cnt_q == CNT_W'(k)) ? coef_q[NA+k] : opa_s;
                    for (int c = 0; c < NCH; c++) begin
                        opb_s = ((cnt_q == CNT_W'(k)) && (ch_q == CH_W'(c))) ?
                                x_hist_q[c][k] : opb_s;
                    end
                end
            end
            default: begin
                opa_s = {Q_BITS{1'b0}};
                opb_s = {Q_BITS{1'b0}};
            end
        endcase
    end

    // In IDLE: history clear beats coefficient write beats sample accept.
    always_comb begin
        x_hist_d = x_hist_q;
        y_hist_d = y_hist_q;
        coef_d   = coef_q;
        if (idle_s && hist_clr) begin
            x_hist_d = '{default: {Q_BITS{1'b0}}};
            y_hist_d = '{default: {Q_BITS{1'b0}}};
        end else if (idle_s && coef_we) begin
            for (int i = 0; i < NA + NB; i++) begin
                coef_d[i] = (coef_addr == AW'(i)) ? coef_wdata : coef_q[i];
            end
        end else if (accept_s) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = NB - 1; k >= 1; k--) begin
                    x_hist_d[c][k] = (in_ch == CH_W'(c)) ? x_hist_q[c][k-1] : x_hist_q[c][k];
                end
                x_hist_d[c][0] = (in_ch == CH_W'(c)) ? x_in_s : x_hist_q[c][0];
            end
        end else if (state_q == DONE) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = NA - 1; k >= 1; k--) begin
                    y_hist_d[c][k] = (ch_q == CH_W'(c)) ? y_hist_q[c][k-1] : y_hist_q[c][k];
                end
                y_hist_d[c][0] = (ch_q == CH_W'(c)) ? y_s : y_hist_q[c][0];
            end
        end else begin
            x_hist_d = x_hist_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        res_d     = res_q;
        res_ch_d  = res_ch_q;
        res_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = MAC_A;
                    cnt_d   = CNT_W'(0);
                    ch_d    = in_ch;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC_A: begin
                if (cnt_q == CNT_W'(NA - 1)) begin
                    state_d = MAC_B;
                    cnt_d   = CNT_W'(0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MAC_B: begin
                if (cnt_q == CNT_W'(NB - 1)) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FLUSH: state_d = DONE;
            DONE: begin
                state_d   = IDLE;
                res_d     = y_s[FRAC_B -: IO_B];
                res_ch_d  = ch_q;
                res_vld_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage retimes the result off the accumulator path.
    always_comb begin
        out_data_d  = res_vld_q ? res_q : out_data_q;
        out_ch_d    = res_vld_q ? res_ch_q : out_ch_q;
        out_valid_d = res_vld_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_W'(0);
            ch_q        <= CH_W'(0);
            x_hist_q    <= '{default: {Q_BITS{1'b0}}};
            y_hist_q    <= '{default: {Q_BITS{1'b0}}};
            coef_q      <= '{default: {Q_BITS{1'b0}}};
            res_q       <= {IO_B{1'b0}};
            res_ch_q    <= CH_W'(0);
            res_vld_q   <= 1'b0;
            out_data_q  <= {IO_B{1'b0}};
            out_ch_q    <= CH_W'(0);
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            x_hist_q    <= x_hist_d;
            y_hist_q    <= y_hist_d;
            coef_q      <= coef_d;
            res_q       <= res_d;
            res_ch_q    <= res_ch_d;
            res_vld_q   <= res_vld_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
